// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Brief    : Shared Wishbone burst constants and master FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_BUS  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/wb_burst_buf.sv
`default_nettype none
// ============================================================================
// Module   : wb_burst_buf
// Brief    : DEPTH x 32 write-data buffer, one synchronous write port and one
//            asynchronous read port. Contents are not reset.
// Revision : 1.0 - initial release
// ============================================================================
module wb_burst_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/wb_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : wb_burst_master
// Brief    : Wishbone pipelined burst master: buffers a write burst, then runs
//            incrementing bursts. WB_BURST_MASTER_TIMEOUT_EN adds ack timeout.
// Revision : 1.0 - initial release
// ============================================================================
module wb_burst_master
    import wb_pkg::*;
#(
    parameter int BURST_MAX      = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    input  logic                         cmd_we_i,
    input  logic [31:0]                  cmd_adr_i,
    input  logic [$clog2(BURST_MAX)-1:0] cmd_len_i,
    input  logic                         wdat_valid_i,
    output logic                         wdat_ready_o,
    input  logic [31:0]                  wdat_i,
    output logic                         rdat_valid_o,
    output logic [31:0]                  rdat_o,
    output logic                         done_o,
    output logic                         err_o,
    output logic [31:0]                  wb_dat_o,
    input  logic [31:0]                  wb_dat_i,
    output logic [31:0]                  wb_adr_o,
    output logic                         wb_we_o,
    output logic [3:0]                   wb_sel_o,
    output logic                         wb_cyc_o,
    output logic                         wb_stb_o,
    output logic [2:0]                   wb_cti_o,
    output logic [1:0]                   wb_bte_o,
    input  logic                         wb_ack_i,
    input  logic                         wb_stall_i
);

    localparam int LW = $clog2(BURST_MAX);

    state_t          r_state, w_next;
    logic [LW-1:0]   r_beat, r_len, w_rd_addr;
    logic            r_we, r_cyc, r_cmd_ready;
    logic [31:0]     w_buf_rdata;
    logic            w_cmd_fire, w_wdat_fire, w_beat_done, w_last, w_tmo_hit;
    logic            w_unused;

    assign w_unused    = ^cmd_adr_i[1:0];
    assign w_cmd_fire  = cmd_valid_i & r_cmd_ready;
    assign w_wdat_fire = wdat_valid_i & (r_state == ST_LOAD);
    assign w_beat_done = r_cyc & wb_ack_i & ~wb_stall_i;
    assign w_last      = (r_beat == r_len);

`ifdef WB_BURST_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmo;
    logic          r_err;

    // Hit on the last permitted ack-less cycle so cyc drops as the count lands.
    assign w_tmo_hit = r_cyc & ~w_beat_done & (r_tmo == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            if (!r_cyc || w_beat_done) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + TW'(1);
            end
            if (w_cmd_fire) begin
                r_err <= 1'b0;
            end else if (w_tmo_hit) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_o = done_o & r_err;
`else
    assign w_tmo_hit = 1'b0;
    assign err_o     = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_cmd_fire) w_next = cmd_we_i ? ST_LOAD : ST_BUS;
            ST_LOAD: if (w_wdat_fire && w_last) w_next = ST_BUS;
            ST_BUS:  if ((w_beat_done && w_last) || w_tmo_hit) w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Prefetch the word for the beat after the current one.
    assign w_rd_addr = (r_state == ST_BUS) ? r_beat + LW'(1) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cmd_ready  <= 1'b0;
            r_cyc        <= 1'b0;
            r_we         <= 1'b0;
            r_len        <= '0;
            r_beat       <= '0;
            wb_we_o      <= 1'b0;
            wb_adr_o     <= '0;
            wb_dat_o     <= '0;
            wb_cti_o     <= CTI_CLASSIC;
            rdat_valid_o <= 1'b0;
            rdat_o       <= '0;
        end else begin
            r_cmd_ready  <= (w_next == ST_IDLE);
            r_cyc        <= (w_next == ST_BUS);
            wb_we_o      <= (w_next == ST_BUS) && (r_state != ST_IDLE) && r_we;
            rdat_valid_o <= w_beat_done & ~r_we;
            if (w_beat_done && !r_we) begin
                rdat_o <= wb_dat_i;
            end
            if (w_cmd_fire) begin
                r_we     <= cmd_we_i;
                r_len    <= cmd_len_i;
                r_beat   <= '0;
                wb_adr_o <= {cmd_adr_i[31:2], 2'b00};
                wb_cti_o <= (cmd_len_i == '0) ? CTI_CLASSIC : CTI_INCR;
            end
            if (w_wdat_fire) begin
                r_beat <= w_last ? '0 : r_beat + LW'(1);
                // Single-word burst: word 0 is being written this very edge.
                if (w_last) begin
                    wb_dat_o <= (r_beat == '0) ? wdat_i : w_buf_rdata;
                end
            end
            if (w_beat_done && !w_last) begin
                r_beat   <= r_beat + LW'(1);
                wb_adr_o <= wb_adr_o + 32'd4;
                wb_dat_o <= w_buf_rdata;
                wb_cti_o <= ((r_beat + LW'(1)) == r_len) ? CTI_EOB : CTI_INCR;
            end
        end
    end

    wb_burst_buf #(
        .DEPTH (BURST_MAX)
    ) u_buf (
        .clk     (clk_i),
        .wr_en   (w_wdat_fire),
        .wr_addr (r_beat),
        .wr_data (wdat_i),
        .rd_addr (w_rd_addr),
        .rd_data (w_buf_rdata)
    );

    assign cmd_ready_o  = r_cmd_ready;
    assign wdat_ready_o = (r_state == ST_LOAD);
    assign done_o       = (r_state == ST_RESP);
    assign wb_cyc_o     = r_cyc;
    assign wb_stb_o     = r_cyc;
    assign wb_sel_o     = 4'b1111;
    assign wb_bte_o     = BTE_LINEAR;

endmodule
`default_nettype wire

// File: tb/tb_wb_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_burst_master
// Brief    : Randomized self-checking bench for wb_burst_master with a RAM
//            slave and a transaction-level expectation model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_burst_master;

    localparam int BURST_MAX = 16;
    localparam int LW        = $clog2(BURST_MAX);
`ifdef WB_BURST_MASTER_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [31:0]   cmd_adr_i;
    logic [LW-1:0] cmd_len_i;
    logic          wdat_valid_i, wdat_ready_o;
    logic [31:0]   wdat_i;
    logic          rdat_valid_o;
    logic [31:0]   rdat_o;
    logic          done_o, err_o;
    logic [31:0]   wb_dat_o, wb_dat_i, wb_adr_o;
    logic          wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_stall_i;
    logic [3:0]    wb_sel_o;
    logic [2:0]    wb_cti_o;
    logic [1:0]    wb_bte_o;

    always #5 clk = ~clk;

    wb_burst_master #(.BURST_MAX(BURST_MAX), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_adr_i(cmd_adr_i), .cmd_len_i(cmd_len_i),
        .wdat_valid_i(wdat_valid_i), .wdat_ready_o(wdat_ready_o), .wdat_i(wdat_i),
        .rdat_valid_o(rdat_valid_o), .rdat_o(rdat_o), .done_o(done_o), .err_o(err_o),
        .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_adr_o(wb_adr_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o),
        .wb_bte_o(wb_bte_o), .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [logic [29:0]];
    logic [31:0] exp_adr[$];
    logic [2:0]  exp_cti[$];
    logic [31:0] exp_wd[$];
    logic [31:0] exp_rd[$];
    logic        exp_we;
    int          g_stall_pct   = 0;
    int          g_force_stall = 0;
    bit          g_mute        = 1'b0;
    bit          hold_pend     = 1'b0;
    logic [31:0] hold_adr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h @%0t", tag, got, expv, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a[31:2])) return mem[a[31:2]];
        return {a[31:2], 2'b00} ^ 32'hA5C3_0F1E;
    endfunction

    // One slave cycle, called at the negedge: chooses ack/stall for the next edge.
    task automatic slave_step(output bit beat);
        logic st, ak;
        st = ($urandom_range(99) < g_stall_pct);
        if (g_force_stall > 0 && wb_cyc_o) begin
            st = 1'b1;
            g_force_stall--;
        end
        ak = !g_mute && !st && ($urandom_range(99) < 75);
        wb_stall_i = st;
        wb_ack_i   = ak;
        wb_dat_i   = mem_rd(wb_adr_o);
        if (hold_pend && wb_cyc_o) check("adr_hold", wb_adr_o, hold_adr);
        beat = wb_cyc_o && wb_stb_o && ak && !st;
        if (beat) begin
            if (exp_adr.size() == 0) begin
                check("beat_extra", 1, 0);
            end else begin
                check("adr", wb_adr_o, exp_adr.pop_front());
                check("cti", 32'(wb_cti_o), 32'(exp_cti.pop_front()));
                check("we", 32'(wb_we_o), 32'(exp_we));
                check("sel_bte", {26'd0, wb_sel_o, wb_bte_o}, 32'h3C);
                if (exp_we) begin
                    check("wdat", wb_dat_o, exp_wd.pop_front());
                    mem[wb_adr_o[31:2]] = wb_dat_o;
                end
            end
        end
        hold_pend = wb_cyc_o && !beat;
        hold_adr  = wb_adr_o;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cmd_valid_i = 1'b0; wdat_valid_i = 1'b0; wb_ack_i = 1'b0; wb_stall_i = 1'b0;
        hold_pend = 1'b0; g_force_stall = 0;
        repeat (2) @(negedge clk);
        check("rst_cyc", 32'(wb_cyc_o), 0);
        check("rst_stb", 32'(wb_stb_o), 0);
        check("rst_we", 32'(wb_we_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_rvalid", 32'(rdat_valid_o), 0);
        check("rst_wready", 32'(wdat_ready_o), 0);
        check("rst_cready", 32'(cmd_ready_o), 0);
        check("rst_cti", 32'(wb_cti_o), 0);
        check("rst_adr", wb_adr_o, 0);
        check("rst_dat", wb_dat_o, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_cready", 32'(cmd_ready_o), 1);
    endtask

    // dmode=1: write data / expected read data is 1,2,3,... per beat.
    task automatic run_cmd(input logic we, input logic [31:0] adr, input int len,
                           input int dmode, input int stall_pct, input int stall_at,
                           input int rst_at, input logic exp_err, output int cyc_hi);
        logic [31:0] wq[$];
        logic [31:0] a0, a, d;
        int  sent = 0, nbeats = 0;
        bit  cmd_done = 1'b0, got_done = 1'b0, beat, stalled = 1'b0;
        exp_adr.delete(); exp_cti.delete(); exp_wd.delete(); exp_rd.delete();
        a0 = {adr[31:2], 2'b00};
        for (int i = 0; i <= len; i++) begin
            a = a0 + 32'(4 * i);
            exp_adr.push_back(a);
            exp_cti.push_back(len == 0 ? 3'b000 : (i == len ? 3'b111 : 3'b010));
            d = (dmode == 1) ? 32'(i + 1) : $urandom();
            if (we) begin
                wq.push_back(d);
                exp_wd.push_back(d);
            end else begin
                exp_rd.push_back(dmode == 1 ? d : mem_rd(a));
            end
        end
        exp_we = we;
        g_stall_pct = stall_pct;
        cyc_hi = 0;
        for (int c = 0; c < 3000 && !got_done; c++) begin
            @(negedge clk);
            if (rdat_valid_o) begin
                if (exp_rd.size() == 0) check("rdat_extra", 1, 0);
                else check("rdat", rdat_o, exp_rd.pop_front());
            end
            if (done_o) begin
                got_done = 1'b1;
                check("err", 32'(err_o), 32'(exp_err));
            end
            if (wb_cyc_o) cyc_hi++;
            if (rst_at >= 0 && nbeats == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_mid_cyc", 32'(wb_cyc_o), 0);
                check("rst_mid_stb", 32'(wb_stb_o), 0);
                check("rst_mid_done", 32'(done_o), 0);
                break;
            end
            if (stall_at >= 0 && nbeats == stall_at && !stalled) begin
                stalled = 1'b1;
                g_force_stall = 3;
            end
            slave_step(beat);
            if (beat) nbeats++;
            if (!cmd_done) begin
                cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_len_i = LW'(len);
                if (cmd_ready_o) cmd_done = 1'b1;
            end else begin
                cmd_valid_i = 1'b0;
            end
            if (we && sent <= len) begin
                wdat_valid_i = ($urandom_range(3) != 0);
                wdat_i = wq[sent];
                if (wdat_valid_i && wdat_ready_o) sent++;
            end else begin
                wdat_valid_i = 1'b0;
            end
        end
        cmd_valid_i = 1'b0;
        wdat_valid_i = 1'b0;
        if (rst_at < 0) begin
            if (!got_done) begin
                check("done_seen", 0, 1);
            end else begin
                if (!exp_err) begin
                    check("beats_left", exp_adr.size(), 0);
                    check("rdat_left", exp_rd.size(), 0);
                end
                @(negedge clk);
                slave_step(beat);
                check("done_one_cycle", 32'(done_o), 0);
            end
        end
    endtask

    int ch;

    initial begin
        cmd_we_i = 1'b0; cmd_adr_i = '0; cmd_len_i = '0; wdat_i = '0; wb_dat_i = '0;
        do_reset();
        mem[30'h10] = 32'hDEAD_BEEF;
        run_cmd(1'b0, 32'h40, 0, 0, 0, -1, -1, 1'b0, ch);
        run_cmd(1'b1, 32'h100, 3, 1, 0, -1, -1, 1'b0, ch);
        run_cmd(1'b0, 32'h100, 3, 1, 20, -1, -1, 1'b0, ch);
        run_cmd(1'b0, 32'hFFFF_FFF0, 15, 0, 25, -1, -1, 1'b0, ch);
        run_cmd(1'b1, 32'h2000, 7, 0, 0, 3, -1, 1'b0, ch);
        run_cmd(1'b0, 32'h2000, 7, 0, 0, 2, -1, 1'b0, ch);
        for (int k = 0; k < 24; k++) begin
            run_cmd(1'($urandom_range(1)), $urandom(), int'($urandom_range(BURST_MAX - 1)),
                    0, 30, -1, -1, 1'b0, ch);
        end
`ifdef WB_BURST_MASTER_TIMEOUT_EN
        g_mute = 1'b1;
        run_cmd(1'b0, 32'h300, 3, 0, 0, -1, -1, 1'b1, ch);
        check("tmo_cyc_cycles", ch, TMO);
        g_mute = 1'b0;
        run_cmd(1'b0, 32'h300, 3, 0, 10, -1, -1, 1'b0, ch);
`endif
        run_cmd(1'b1, 32'h500, 7, 0, 0, -1, 2, 1'b0, ch);
        do_reset();
        run_cmd(1'b1, 32'h500, 7, 0, 20, -1, -1, 1'b0, ch);
        run_cmd(1'b0, 32'h500, 7, 0, 20, -1, -1, 1'b0, ch);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 SHALL have parameter BURST_MAX, default 16, maximum beats per command (power of two).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, ack-wait limit used only when the timeout feature is compiled in.
REQ-003 SHALL have clk_i  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have rst_ni  in  1  asynchronous, active-low reset.
REQ-005 SHALL have cmd_valid_i / cmd_ready_o  in / out  1 / 1  command handshake.
REQ-006 SHALL have cmd_we_i  in  1  1 = write burst, 0 = read burst.
REQ-007 SHALL have cmd_adr_i  in  32  byte start address; bits [1:0] ignored and driven 0 on the bus.
REQ-008 SHALL have cmd_len_i  in  $clog2(BURST_MAX)  beat count minus one.
REQ-009 SHALL have wdat_valid_i / wdat_ready_o / wdat_i  in / out / in  1 / 1 / 32  write-data stream.
REQ-010 SHALL have rdat_valid_o / rdat_o  out / out  1 / 32  read-data stream; no backpressure.
REQ-011 SHALL have done_o / err_o  out / out  1 / 1  one-cycle completion pulse and its error qualifier.
REQ-012 SHALL have Wishbone master ports wb_dat_o[31:0], wb_dat_i[31:0], wb_adr_o[31:0], wb_we_o, wb_sel_o[3:0], wb_cyc_o, wb_stb_o, wb_cti_o[2:0], wb_bte_o[1:0], wb_ack_i, wb_stall_i.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, BUS, RESP.
REQ-014 IDLE: cmd_ready_o=1; on cmd_valid_i, latch the command and go to LOAD if write, else BUS.
REQ-015 LOAD: wdat_ready_o=1; each wdat handshake stores one word into the buffer; after len+1 words, go to BUS the next cycle.
REQ-016 BUS: wb_cyc_o=wb_stb_o=1, wb_sel_o=4'b1111, wb_bte_o=2'b00, and wb_we_o=latched we.
REQ-017 One beat SHALL complete on each cycle with wb_cyc_o & wb_stb_o & wb_ack_i & !wb_stall_i; the address advances by 4 and the beat counter by 1, registered.
REQ-018 wb_cti_o SHALL be 3'b000 for a single-beat command, 3'b010 on non-final burst beats, and 3'b111 on the final burst beat.
REQ-019 Write beats SHALL drive wb_dat_o from buffer[beat]; read beats SHALL assert rdat_valid_o with rdat_o=wb_dat_i in the cycle after the ack, one pulse per beat, in order.
REQ-020 On the final beat's ack: wb_cyc_o and wb_stb_o SHALL be 0 the next cycle; the FSM enters RESP.
REQ-021 RESP: done_o=1 for exactly one cycle with err_o qualifying it; return to IDLE; the next command may be accepted the following cycle.
REQ-022 Address SHALL wrap modulo 2^32 without error.
REQ-023 cmd_ready_o SHALL be 0 outside IDLE; wdat_ready_o SHALL be 0 outside LOAD.
REQ-024 All bus outputs SHALL be registered; wb_ack_i arriving outside BUS SHALL be ignored.

Reset
REQ-025 Reset SHALL force IDLE, with wb_cyc_o, wb_stb_o, wb_we_o, done_o, err_o, rdat_valid_o and wdat_ready_o at 0, cmd_ready_o at 0 during reset and 1 after, wb_cti_o at 3'b000, and wb_adr_o/wb_dat_o at 0.
REQ-026 Reset asserted mid-burst SHALL drop wb_cyc_o immediately (asynchronously), discard the command without a done_o pulse, and leave buffer contents undefined.

Configuration
REQ-027 Macro WB_BURST_MASTER_TIMEOUT_EN: when defined, a counter SHALL clear on each completed beat and increment on every BUS cycle without ack.
REQ-028 When that counter reaches TIMEOUT_CYCLES, the master SHALL drop cyc/stb the next cycle and pulse done_o with err_o=1.
REQ-029 Without WB_BURST_MASTER_TIMEOUT_EN, the master SHALL wait indefinitely for ack and err_o SHALL be tied to 0.

Structure
REQ-030 Shared package wb_pkg SHALL hold the CTI constants (CLASSIC=000, INCR=010, EOB=111), the BTE_LINEAR constant, and the FSM state enum.
REQ-031 The write buffer SHALL be a sub-module wb_burst_buf (BURST_MAX x 32, one write port and one read port).

Verification
REQ-032 Single read from 0x40 with len=0, RAM slave preloaded 0xDEADBEEF -> cti=000, one rdat pulse of 0xDEADBEEF, done_o=1 and err_o=0.
REQ-033 Write of 4 beats to 0x100 with data 1,2,3,4 -> cti sequence 010,010,010,111 at addresses 0x100–0x10C; cyc low after the fourth ack; readback matches.
REQ-034 16-beat read at 0xFFFFFFF0 -> address wraps to 0x00000000 at beat 4; 16 ordered rdat pulses; no error.
REQ-035 wb_stall_i held high for 3 cycles mid-burst -> beat counter and address hold; data intact.
REQ-036 With TIMEOUT_EN and TIMEOUT_CYCLES=8, no ack from the slave -> cyc drops after 8 wait cycles and done_o=1 with err_o=1; a subsequent command succeeds.
REQ-037 rst_ni pulsed low at beat 2 of an 8-beat write -> cyc=0 immediately, no done_o pulse; a fresh command after reset completes normally.
